// File: rtl/branch_resolver.sv
//------------------------------------------------------------------------------
// Module      : branch_resolver
// Description : In-order queue of branch predictions. Each fetched branch
//               pushes its predicted direction. Each resolution pops the
//               oldest entry, sends a one-cycle training strobe to the
//               predictor, and flushes the whole queue on a mispredict.
//               Optional statistics counters are enabled by defining
//               BRANCH_RESOLVER_STATS_EN. Without it they are tied to zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    output logic                       upd_valid,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           total_cnt,
    output logic [CNT_W-1:0]           miss_cnt
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_occ_w = $clog2(DEPTH + 1);
    localparam logic [c_occ_w-1:0] c_full    = c_occ_w'(DEPTH);
    localparam logic [c_occ_w-1:0] c_occ_one = c_occ_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [DEPTH-1:0]   r_mem;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_occ_w-1:0] r_occ;
    logic               r_upd_valid;
    logic               r_upd_taken;
    logic               r_mispredict;

    logic               w_push;
    logic               w_pop;
    logic               w_head_pred;
    logic               w_miss;
    logic [c_occ_w-1:0] w_occ_nxt;

    // Handshakes depend only on the registered occupancy, so a full queue
    // refuses a push even when a pop happens in the same cycle.
    assign pred_ready  = (r_occ != c_full);
    assign res_ready   = (r_occ != '0);
    assign w_push      = pred_valid && pred_ready;
    assign w_pop       = res_valid && res_ready;
    assign w_head_pred = r_mem[r_head];
    assign w_miss      = w_pop && (res_taken != w_head_pred);

    // Next occupancy. A mispredict flushes everything, including a push
    // accepted in the same cycle.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_miss) begin
            w_occ_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + c_occ_one;
        end else if (!w_push && w_pop) begin
            w_occ_nxt = r_occ - c_occ_one;
        end
    end

    // Queue pointers and occupancy. The pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_miss) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_ptr_one;
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_one;
                end
            end
        end
    end

    // Prediction storage. The contents do not matter once the pointers are
    // reset, so the storage itself has no reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push && !w_miss) begin
            r_mem[r_tail] <= pred_taken;
        end
    end

    // One-cycle training strobe and flush pulse following a resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd_valid  <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_upd_valid  <= w_pop;
            r_upd_taken  <= w_pop && res_taken;
            r_mispredict <= w_miss;
        end
    end

    assign upd_valid  = r_upd_valid;
    assign upd_taken  = r_upd_taken;
    assign mispredict = r_mispredict;
    assign occupancy  = r_occ;

`ifdef BRANCH_RESOLVER_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [CNT_W-1:0] r_total_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Saturating counters for resolved branches and mispredicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_total_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            if (w_pop && (r_total_cnt != '1)) begin
                r_total_cnt <= r_total_cnt + c_cnt_one;
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + c_cnt_one;
            end
        end
    end

    assign total_cnt = r_total_cnt;
    assign miss_cnt  = r_miss_cnt;
`else
    assign total_cnt = '0;
    assign miss_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
//------------------------------------------------------------------------------
// Module      : tb_branch_resolver
// Description : Scoreboard bench for branch_resolver. It compares the design
//               against a queue model of in-flight predictions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int c_cnt_max = (1 << CNT_W) - 1;

    logic                       clk;
    logic                       reset;
    logic                       pred_valid;
    logic                       pred_taken;
    logic                       pred_ready;
    logic                       res_valid;
    logic                       res_taken;
    logic                       res_ready;
    logic                       upd_valid;
    logic                       upd_taken;
    logic                       mispredict;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [CNT_W-1:0]           total_cnt;
    logic [CNT_W-1:0]           miss_cnt;

    branch_resolver #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_ready  (res_ready),
        .upd_valid  (upd_valid),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .occupancy  (occupancy),
        .total_cnt  (total_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit taken;
        bit miss;
    } exp_t;

    exp_t sb[$];
    bit   model_q[$];
    int   exp_total;
    int   exp_miss;
    int   cyc;
    bit   mon_en;
    int   n_total;
    int   n_bad;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: whenever an update is due, the strobe and its payload must match.
    // Every other cycle must be idle with zeroed payload.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                chk("upd_missed", 32'd0, 32'd1);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("upd_valid", upd_valid, 1);
                chk("upd_taken", upd_taken, mon_e.taken);
                chk("mispredict", mispredict, mon_e.miss);
            end else begin
                chk("upd_valid_idle", upd_valid, 0);
                chk("upd_taken_idle", upd_taken, 0);
                chk("mispredict_idle", mispredict, 0);
            end
        end
    end

    // One clock cycle. First check the visible state against the model.
    // Then drive inputs, predict the outcome, and advance the model after the edge.
    task automatic cycle(input bit pv, input bit pt, input bit rv, input bit rt, input bit rs);
        bit push;
        bit pop;
        bit miss;
        int occ;
        occ = model_q.size();
        chk("occupancy", occupancy, occ);
        chk("pred_ready", pred_ready, (occ != DEPTH) ? 1 : 0);
        chk("res_ready", res_ready, (occ != 0) ? 1 : 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("total_cnt", total_cnt, exp_total);
        chk("miss_cnt", miss_cnt, exp_miss);
`else
        chk("total_cnt", total_cnt, 0);
        chk("miss_cnt", miss_cnt, 0);
`endif
        reset      = rs;
        pred_valid = pv;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        push = !rs && pv && (occ < DEPTH);
        pop  = !rs && rv && (occ > 0);
        miss = pop && (rt != model_q[0]);
        if (pop) sb.push_back('{due: cyc + 1, taken: rt, miss: miss});
        @(posedge clk);
        #1;
        if (rs) begin
            model_q.delete();
            exp_total = 0;
            exp_miss  = 0;
        end else begin
            if (pop) begin
                void'(model_q.pop_front());
                if (exp_total < c_cnt_max) exp_total++;
                if (miss && exp_miss < c_cnt_max) exp_miss++;
            end
            if (miss) model_q.delete();
            else if (push) model_q.push_back(pt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit p[10];
        bit head;
        bit pv;
        bit rv;
        bit rt;
        n_total = 0; n_bad = 0; exp_total = 0; exp_miss = 0; cyc = 0; mon_en = 0;
        reset = 1'b1; pred_valid = 1'b1; pred_taken = 1'b1; res_valid = 1'b1; res_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pred_valid = 1'b0; res_valid = 1'b0;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_pred_ready", pred_ready, 1);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_total_cnt", total_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        mon_en = 1'b1;

        // Fill with 1,1,0,1; a fifth push is refused.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        chk("full_occupancy", occupancy, 4);
        chk("full_pred_ready", pred_ready, 0);
        cycle(1, 0, 0, 0, 0);
        chk("refused_push", occupancy, 4);

        // Resolve in order with correct outcomes.
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("four_resolved", total_cnt, 4);
        chk("no_misses", miss_cnt, 0);
`endif

        // Queue 1,0,0; resolving the head as not-taken flushes the queue.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_mispredict", mispredict, 1);
        chk("flush_upd_taken", upd_taken, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("flush_miss_cnt", miss_cnt, 1);
`endif

        // Full queue with push and pop in the same cycle: only the pop happens.
        repeat (4) cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 1, 0);
        chk("full_push_pop", occupancy, 3);
        cycle(0, 0, 1, 1, 0);
        cycle(1, 1, 1, 1, 0);
        chk("half_push_pop", occupancy, 2);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);

        // Stream ten entries through to cross the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            p[i] = 1'($urandom);
            cycle(1, p[i], (i > 0) ? 1'b1 : 1'b0, (i > 0) ? p[(i > 0) ? i - 1 : 0] : 1'b0, 0);
        end
        cycle(0, 0, 1, p[9], 0);

        // Reset with three entries held and handshakes active.
        repeat (3) cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 1);
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_upd_valid", upd_valid, 0);
        cycle(0, 0, 0, 0, 0);

        // Random traffic, mostly correct predictions with occasional misses and resets.
        for (int i = 0; i < 3000; i++) begin
            head = (model_q.size() > 0) ? model_q[0] : 1'b0;
            pv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            rt = ($urandom_range(0, 9) == 0) ? ~head : head;
            cycle(pv, 1'($urandom), rv, rt, ($urandom_range(0, 199) == 0));
        end

        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of in-flight prediction entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, the statistics counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port pred_valid, input, 1, a prediction is offered for a newly fetched branch.
REQ-006 The block SHALL have port pred_taken, input, 1, the offered predicted direction (1 = taken).
REQ-007 The block SHALL have port pred_ready, output, 1, high when the queue is not full.
REQ-008 The block SHALL have port res_valid, input, 1, the oldest in-flight branch is resolved.
REQ-009 The block SHALL have port res_taken, input, 1, the actual branch outcome.
REQ-010 The block SHALL have port res_ready, output, 1, high when the queue is not empty.
REQ-011 The block SHALL have port upd_valid, output, 1, a one-cycle training strobe to the predictor.
REQ-012 The block SHALL have port upd_taken, output, 1, the actual outcome, driven to the predictor taken input.
REQ-013 The block SHALL have port mispredict, output, 1, a one-cycle flush pulse.
REQ-014 The block SHALL have port occupancy, output, clog2(DEPTH+1), the number of valid entries.
REQ-015 The block SHALL have ports total_cnt and miss_cnt, output, CNT_W each, the resolved-branch and mispredict counts.

Function
REQ-016 The block SHALL accept a prediction when pred_valid && pred_ready and append pred_taken at the queue tail.
REQ-017 The block SHALL accept a resolution when res_valid && res_ready, pop the head, and compare res_taken with the head pred_taken.
REQ-018 The block SHALL derive pred_ready and res_ready combinationally from the registered occupancy only: full blocks a push even in a cycle with a pop, and empty ignores res_valid.
REQ-019 The block SHALL support a simultaneous accepted push and pop with occupancy unchanged, except as overridden by REQ-021.
REQ-020 The block SHALL register upd_valid, upd_taken = res_taken and mispredict = (res_taken != head pred_taken) in the cycle after an accepted resolution, and hold each high for exactly one cycle.
REQ-021 On an accepted mispredicting resolution, the block SHALL empty the queue at that clock edge, discarding all younger entries and any push accepted in the same cycle, so that occupancy = 0 on the next cycle.
REQ-022 On correctly predicted resolutions, the block SHALL leave younger entries intact and in order.
REQ-023 The block SHALL wrap the head and tail pointers modulo DEPTH with no entry loss or duplication across the wrap.
REQ-024 The block SHALL drive upd_valid = 0 in every cycle not following an accepted resolution, and SHALL then drive upd_taken and mispredict to 0.

Reset
REQ-025 While reset = 1 at a clock edge, the block SHALL clear the queue, set occupancy = 0, and force pred_ready = 1, res_ready = 0, upd_valid = upd_taken = mispredict = 0, and total_cnt = miss_cnt = 0.
REQ-026 When reset is asserted mid-operation, the block SHALL discard all in-flight entries and suppress any pending update strobe.
REQ-027 The block SHALL ignore handshakes presented in the reset cycle.

Configuration
REQ-028 With macro BRANCH_RESOLVER_STATS_EN defined, the block SHALL increment total_cnt on every accepted resolution and miss_cnt on every mispredict, both saturating at 2^CNT_W-1.
REQ-029 Without BRANCH_RESOLVER_STATS_EN, the block SHALL omit the counters and tie total_cnt and miss_cnt to 0.

Verification (DEPTH=4, CNT_W=16, STATS_EN defined)
REQ-030 Push 4 predictions 1,1,0,1 -> occupancy = 4, pred_ready = 0; a 5th push is refused.
REQ-031 Resolve 1,1,0,1 against that queue -> 4 upd_valid pulses with upd_taken 1,1,0,1, mispredict never set, total_cnt = 4, miss_cnt = 0.
REQ-032 Queue holds 1,0,0; resolve with res_taken = 0 -> next cycle mispredict = 1, upd_taken = 0, occupancy = 0, miss_cnt += 1.
REQ-033 Full queue with a simultaneous push and correct pop -> push refused, occupancy = 3; at occupancy 2, a simultaneous push and pop leaves occupancy = 2.
REQ-034 Run 10 pushes/pops to cross the pointer wrap -> outputs match pushed order; assert reset with 3 entries held -> occupancy = 0 and no upd_valid next cycle.
